// File: rtl/mips_pkg.sv
// Shared constants for the MIPS multicycle control path: opcodes, functs,
// ALU operation codes (also used by the ALU), mux selects and FSM states.
package mips_pkg;

  // Primary opcodes, instr[31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type function codes, instr[5:0]
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU operation codes; the supported functs carry their op code in bits [3:0]
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_AND = 4'b0100;
  localparam logic [3:0] ALU_OR  = 4'b0101;
  localparam logic [3:0] ALU_XOR = 4'b0110;
  localparam logic [3:0] ALU_NOR = 4'b0111;
  localparam logic [3:0] ALU_SLT = 4'b1010;

  // Coarse ALU request from the FSM to the ALU decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU B-operand select
  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Control FSM states; codes 12..15 are unreachable and recover to FETCH
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_e;

  // True for every opcode the control unit knows how to sequence
  function automatic logic is_supported_op(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ)   || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU decoder: turns the FSM's coarse ALU request and the
// instruction funct field into the 4-bit ALU operation, flagging unknown functs.
module alu_decoder
  import mips_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [5:0] funct_i,
  output logic [3:0] alu_control_o,
  output logic       funct_illegal_o
);

  // Select the ALU operation; an unknown funct falls back to ADD
  always_comb begin
    alu_control_o   = ALU_ADD;
    funct_illegal_o = 1'b0;
    case (alu_op_i)
      ALUOP_ADD: alu_control_o = ALU_ADD;
      ALUOP_SUB: alu_control_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct_i)
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT:
            alu_control_o = funct_i[3:0];
          default: begin
            alu_control_o   = ALU_ADD;
            funct_illegal_o = 1'b1;
          end
        endcase
      end
      default: alu_control_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control unit: sequences fetch/decode/execute/memory/writeback,
// drives the datapath enables and the ALU operation, and consumes the Zero flag.
module mips_multicycle_control
  import mips_pkg::*;
(
  input  logic       CLK,
  input  logic       RESET,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic [3:0] ALUControl,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic       PCEn,
  output logic       Illegal
);

  state_e     state_q;
  state_e     state_d;

  logic [1:0] alu_op;
  logic [3:0] alu_ctl;
  logic       funct_illegal;

  logic       iord_raw;
  logic       memwrite_raw;
  logic       irwrite_raw;
  logic       regdst_raw;
  logic       memtoreg_raw;
  logic       regwrite_raw;
  logic       alusrca_raw;
  logic [1:0] alusrcb_raw;
  logic [1:0] pcsrc_raw;
  logic       pc_write;
  logic       branch;
  logic       op_illegal;
  logic       gate_off;

  alu_decoder u_alu_decoder (
    .alu_op_i        (alu_op),
    .funct_i         (Funct),
    .alu_control_o   (alu_ctl),
    .funct_illegal_o (funct_illegal)
  );

  // State register; reset returns to FETCH from any state, even mid-instruction
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state sequencing; opcode/funct are only consulted once the IR is stable
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        case (Opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEXEC;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:    state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWR:    state_d = S_FETCH;
      // A bad funct abandons the instruction without writing back
      S_EXECUTE:  state_d = funct_illegal ? S_FETCH : S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_ADDIEXEC: state_d = S_ADDIWB;
      S_ADDIWB:   state_d = S_FETCH;
      S_JUMP:     state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  // Per-state datapath controls before reset gating; unlisted controls stay 0
  always_comb begin
    alu_op       = ALUOP_ADD;
    iord_raw     = 1'b0;
    memwrite_raw = 1'b0;
    irwrite_raw  = 1'b0;
    regdst_raw   = 1'b0;
    memtoreg_raw = 1'b0;
    regwrite_raw = 1'b0;
    alusrca_raw  = 1'b0;
    alusrcb_raw  = SRCB_RT;
    pcsrc_raw    = PCSRC_ALU;
    pc_write     = 1'b0;
    branch       = 1'b0;
    op_illegal   = 1'b0;
    case (state_q)
      S_FETCH: begin
        irwrite_raw = 1'b1;
        alusrcb_raw = SRCB_FOUR;
        pc_write    = 1'b1;
      end
      S_DECODE: begin
        // Branch target is computed speculatively into ALUOut
        alusrcb_raw = SRCB_IMM_SH2;
        op_illegal  = !is_supported_op(Opcode);
      end
      S_MEMADR: begin
        alusrca_raw = 1'b1;
        alusrcb_raw = SRCB_IMM;
      end
      S_MEMRD: begin
        iord_raw = 1'b1;
      end
      S_MEMWB: begin
        // Address stays on ALUOut so the read data is held through writeback
        iord_raw     = 1'b1;
        memtoreg_raw = 1'b1;
        regwrite_raw = 1'b1;
      end
      S_MEMWR: begin
        iord_raw     = 1'b1;
        memwrite_raw = 1'b1;
      end
      S_EXECUTE: begin
        alu_op      = ALUOP_FUNCT;
        alusrca_raw = 1'b1;
      end
      S_ALUWB: begin
        regdst_raw   = 1'b1;
        regwrite_raw = 1'b1;
      end
      S_BRANCH: begin
        alu_op      = ALUOP_SUB;
        alusrca_raw = 1'b1;
        pcsrc_raw   = PCSRC_ALUOUT;
        branch      = 1'b1;
      end
      S_ADDIEXEC: begin
        alusrca_raw = 1'b1;
        alusrcb_raw = SRCB_IMM;
      end
      S_ADDIWB: begin
        regwrite_raw = 1'b1;
      end
      S_JUMP: begin
        pcsrc_raw = PCSRC_JUMP;
        pc_write  = 1'b1;
      end
      default: ;
    endcase
  end

  // While reset is held only the FETCH decode may reach the datapath
  always_comb begin
    gate_off   = RESET && (state_q != S_FETCH);
    ALUControl = gate_off ? ALU_ADD   : alu_ctl;
    IorD       = gate_off ? 1'b0      : iord_raw;
    MemWrite   = gate_off ? 1'b0      : memwrite_raw;
    IRWrite    = gate_off ? 1'b0      : irwrite_raw;
    RegDst     = gate_off ? 1'b0      : regdst_raw;
    MemtoReg   = gate_off ? 1'b0      : memtoreg_raw;
    RegWrite   = gate_off ? 1'b0      : regwrite_raw;
    ALUSrcA    = gate_off ? 1'b0      : alusrca_raw;
    ALUSrcB    = gate_off ? SRCB_RT   : alusrcb_raw;
    PCSrc      = gate_off ? PCSRC_ALU : pcsrc_raw;
    PCEn       = gate_off ? 1'b0      : (pc_write | (branch & Zero));
    Illegal    = gate_off ? 1'b0      : (op_illegal | funct_illegal);
  end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Bench for mips_multicycle_control: instruction-level model of expected
// per-cycle control words, a per-cycle compare process, and literal pins.
module tb_mips_multicycle_control;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [5:0] Opcode;
  logic [5:0] Funct;
  logic       Zero;
  logic [3:0] ALUControl;
  logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, PCSrc;
  logic       PCEn, Illegal;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;
  logic [16:0] exp_q[$];

  always #5 CLK = ~CLK;

  mips_multicycle_control dut (
    .CLK(CLK), .RESET(RESET), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
    .ALUControl(ALUControl), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .PCEn(PCEn), .Illegal(Illegal)
  );

  wire [16:0] act = {ALUControl, IorD, MemWrite, IRWrite, RegDst, MemtoReg,
                     RegWrite, ALUSrcA, ALUSrcB, PCSrc, PCEn, Illegal};

  // Control word layout: alu iord memw irw regdst m2r regw srca srcb pcsrc pcen ill
  function automatic logic [16:0] mk(input logic [3:0] alu, input logic iord,
      input logic memw, input logic irw, input logic regdst, input logic m2r,
      input logic regw, input logic srca, input logic [1:0] srcb,
      input logic [1:0] pcsrc, input logic pcen, input logic ill);
    return {alu, iord, memw, irw, regdst, m2r, regw, srca, srcb, pcsrc, pcen, ill};
  endfunction

  // Appends the expected control word for every cycle of one instruction
  function automatic int push_model(input logic [5:0] op, input logic [5:0] fn,
                                    input logic z);
    logic [3:0] code;
    logic       ok;
    int n;
    n = 0;
    // fetch: PC+4, load IR
    exp_q.push_back(mk(4'b0000,0,0,1,0,0,0,0,2'b01,2'b00,1,0)); n++;
    ok = (op == 6'b000000) || (op == 6'b100011) || (op == 6'b101011) ||
         (op == 6'b000100) || (op == 6'b001000) || (op == 6'b000010);
    exp_q.push_back(mk(4'b0000,0,0,0,0,0,0,0,2'b11,2'b00,0,!ok)); n++;
    if (op == 6'b100011) begin
      exp_q.push_back(mk(4'b0000,0,0,0,0,0,0,1,2'b10,2'b00,0,0)); n++;
      exp_q.push_back(mk(4'b0000,1,0,0,0,0,0,0,2'b00,2'b00,0,0)); n++;
      exp_q.push_back(mk(4'b0000,1,0,0,0,1,1,0,2'b00,2'b00,0,0)); n++;
    end else if (op == 6'b101011) begin
      exp_q.push_back(mk(4'b0000,0,0,0,0,0,0,1,2'b10,2'b00,0,0)); n++;
      exp_q.push_back(mk(4'b0000,1,1,0,0,0,0,0,2'b00,2'b00,0,0)); n++;
    end else if (op == 6'b000000) begin
      ok = 1'b1;
      case (fn)
        6'b100000: code = 4'b0000;
        6'b100010: code = 4'b0010;
        6'b100100: code = 4'b0100;
        6'b100101: code = 4'b0101;
        6'b100110: code = 4'b0110;
        6'b100111: code = 4'b0111;
        6'b101010: code = 4'b1010;
        default: begin code = 4'b0000; ok = 1'b0; end
      endcase
      exp_q.push_back(mk(code,0,0,0,0,0,0,1,2'b00,2'b00,0,!ok)); n++;
      if (ok) begin
        exp_q.push_back(mk(4'b0000,0,0,0,1,0,1,0,2'b00,2'b00,0,0)); n++;
      end
    end else if (op == 6'b000100) begin
      exp_q.push_back(mk(4'b0010,0,0,0,0,0,0,1,2'b00,2'b01,z,0)); n++;
    end else if (op == 6'b001000) begin
      exp_q.push_back(mk(4'b0000,0,0,0,0,0,0,1,2'b10,2'b00,0,0)); n++;
      exp_q.push_back(mk(4'b0000,0,0,0,0,0,1,0,2'b00,2'b00,0,0)); n++;
    end else if (op == 6'b000010) begin
      exp_q.push_back(mk(4'b0000,0,0,0,0,0,0,0,2'b00,2'b10,1,0)); n++;
    end
    return n;
  endfunction

  // Per-cycle comparison of every output against the model
  always @(negedge CLK) begin
    logic [16:0] e;
    if (chk_en) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL model_underflow t=%0t got=%b required=<none>", $time, act);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          errors++;
          $display("FAIL outputs t=%0t op=%b fn=%b got=%b required=%b",
                   $time, Opcode, Funct, act, e);
        end
      end
    end
  end

  task automatic pin(input string name, input logic [15:0] got, input logic [15:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s t=%0t got=%h required=%h", name, $time, got, req);
    end
  endtask

  // Runs one instruction; lit_cycles and lit_alu are hand-computed expectations
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int lit_cycles, input logic [3:0] lit_alu);
    int n;
    Opcode = op; Funct = fn; Zero = z;
    n = push_model(op, fn, z);
    pin("model_cycles", 16'(n), 16'(lit_cycles));
    for (int c = 1; c <= n; c++) begin
      @(negedge CLK);
      if (op == 6'b000000 && c == 3) pin("r_alucontrol", 16'(ALUControl), 16'(lit_alu));
      if (op == 6'b100011 && c == 5) pin("lw_wb", 16'({RegWrite, MemtoReg, IorD}), 16'h7);
      if (op == 6'b100011 && c == 4) pin("lw_rd", 16'({RegWrite, IorD}), 16'h1);
      if (op == 6'b000100 && c == 3)
        pin("beq", 16'({PCEn, PCSrc, ALUControl}), 16'({z, 2'b01, 4'b0010}));
      if (op == 6'b000010 && c == 3) pin("jump", 16'({PCSrc, PCEn}), 16'h5);
      if (op == 6'b111111 && c == 2)
        pin("illegal_op", 16'({Illegal, RegWrite, MemWrite}), 16'h4);
      @(posedge CLK); #1;
    end
  endtask

  initial begin
    RESET = 1'b1; Opcode = 6'b000000; Funct = 6'b100000; Zero = 1'b0;
    @(posedge CLK); #1;
    // Reset still held, state already FETCH: FETCH decode is visible
    exp_q.push_back(mk(4'b0000,0,0,1,0,0,0,0,2'b01,2'b00,1,0));
    chk_en = 1'b1;
    @(negedge CLK);
    pin("reset_fetch", 16'({IRWrite, PCEn, MemWrite, RegWrite}), 16'hC);
    @(posedge CLK); #1;
    RESET = 1'b0;

    run_instr(6'b100011, 6'b000000, 1'b1, 5, 4'b0000);   // lw
    run_instr(6'b101011, 6'b000000, 1'b1, 4, 4'b0000);   // sw
    run_instr(6'b000000, 6'b100000, 1'b1, 4, 4'b0000);   // add
    run_instr(6'b000000, 6'b100010, 1'b0, 4, 4'b0010);   // sub
    run_instr(6'b000000, 6'b100100, 1'b1, 4, 4'b0100);   // and
    run_instr(6'b000000, 6'b100101, 1'b0, 4, 4'b0101);   // or
    run_instr(6'b000000, 6'b100110, 1'b1, 4, 4'b0110);   // xor
    run_instr(6'b000000, 6'b100111, 1'b0, 4, 4'b0111);   // nor
    run_instr(6'b000000, 6'b101010, 1'b1, 4, 4'b1010);   // slt
    run_instr(6'b000000, 6'b000000, 1'b1, 3, 4'b0000);   // bad funct
    run_instr(6'b000100, 6'b000000, 1'b1, 3, 4'b0000);   // beq taken
    run_instr(6'b000100, 6'b000000, 1'b0, 3, 4'b0000);   // beq not taken
    run_instr(6'b001000, 6'b000000, 1'b1, 4, 4'b0000);   // addi
    run_instr(6'b000010, 6'b000000, 1'b0, 3, 4'b0000);   // j
    run_instr(6'b111111, 6'b000000, 1'b1, 2, 4'b0000);   // illegal opcode

    // sw interrupted by reset in MEMWR
    Opcode = 6'b101011; Funct = 6'b000000; Zero = 1'b1;
    void'(push_model(6'b101011, 6'b000000, 1'b1));
    exp_q[exp_q.size()-1] = 17'd0;
    for (int c = 1; c <= 3; c++) begin
      @(posedge CLK); #1;
    end
    RESET = 1'b1;
    @(negedge CLK);
    pin("reset_memwr", 16'({MemWrite, IorD, IRWrite}), 16'h0);
    @(posedge CLK); #1;
    exp_q.push_back(mk(4'b0000,0,0,1,0,0,0,0,2'b01,2'b00,1,0));
    @(negedge CLK);
    pin("reset_to_fetch", 16'({MemWrite, IRWrite, PCEn}), 16'h3);
    @(posedge CLK); #1;
    RESET = 1'b0;

    run_instr(6'b100011, 6'b000000, 1'b0, 5, 4'b0000);   // lw after reset
    chk_en = 1'b0;

    pin("model_drained", 16'(exp_q.size()), 16'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
